// File: rtl/am_pkg.sv
// am_pkg: shared constants, types and the sine table generator for the
// DDS-based AM source (am_modulator) and its sine ROM.
package am_pkg;

    localparam int unsigned AM_W       = 16;
    localparam int unsigned PHASE_W    = 32;
    localparam int          ENV_OFFSET = 16384;
    localparam int unsigned ENV_SHIFT  = 9;
    localparam int unsigned PROD_SHIFT = 15;

    // Signed product widths for the envelope and output multipliers
    localparam int unsigned ENV_W  = 24;
    localparam int unsigned PROD_W = 32;

    localparam logic [PHASE_W-1:0] CAR_FTW_DEFAULT = 32'h0400_0000;
    localparam logic [PHASE_W-1:0] MSG_FTW_DEFAULT = 32'h0008_0000;

    localparam real PI = 3.14159265358979323846;

    typedef logic signed [AM_W-1:0] sample_t;
    typedef logic [PHASE_W-1:0]     phase_t;

    // Table entry k of a 2^aw full-wave sine, scaled to 32767,
    // rounded half away from zero. Evaluated at elaboration only.
    function automatic sample_t sine_entry(int k, int unsigned aw);
        real x;
        x = 32767.0 * $sin(2.0 * PI * real'(k) / real'(1 << aw));
        if (x >= 0.0) return sample_t'($rtoi(x + 0.5));
        else          return sample_t'($rtoi(x - 0.5));
    endfunction

endpackage

// File: rtl/am_modulator_if.sv
// am_modulator_if: control inputs and sample output of am_modulator.
//   en          advance both phase accumulators, tag sample valid
//   phase_clr   synchronously zero both phase accumulators
//   ftw_load    capture car_ftw_in / msg_ftw_in
//   car_ftw_in  new carrier tuning word
//   msg_ftw_in  new message tuning word
//   AM_mod      signed AM sample
//   am_valid    AM_mod was taken with en=1
interface am_modulator_if;
    import am_pkg::*;

    logic    en;
    logic    phase_clr;
    logic    ftw_load;
    phase_t  car_ftw_in;
    phase_t  msg_ftw_in;
    sample_t AM_mod;
    logic    am_valid;

    modport master (
        output en, phase_clr, ftw_load, car_ftw_in, msg_ftw_in,
        input  AM_mod, am_valid
    );

    modport slave (
        input  en, phase_clr, ftw_load, car_ftw_in, msg_ftw_in,
        output AM_mod, am_valid
    );

endinterface

// File: rtl/am_modulator_sine_rom.sv
// sine_rom: full-wave sine table with two independent read ports and
// registered outputs (one clock read latency). Table is generated at
// elaboration.
//   clk, rst_n        clock, asynchronous active-low reset (outputs -> 0)
//   addr_a, addr_b    read addresses
//   data_a, data_b    registered table entries
module sine_rom
    import am_pkg::*;
#(
    parameter int unsigned LUT_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LUT_AW-1:0] addr_a,
    input  logic [LUT_AW-1:0] addr_b,
    output sample_t           data_a,
    output sample_t           data_b
);

    localparam int DEPTH = 1 << LUT_AW;

    sample_t table_w [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
        localparam sample_t V = sine_entry(k, LUT_AW);
        assign table_w[k] = V;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a <= '0;
            data_b <= '0;
        end else begin
            data_a <= table_w[addr_a];
            data_b <= table_w[addr_b];
        end
    end

endmodule

// File: rtl/am_modulator.sv
// am_modulator: DDS AM source. Two 32-bit phase accumulators address a
// shared sine ROM; the message forms the envelope 1 + m*msg, which then
// scales the carrier. Fixed 3-clock latency from phase register to AM_mod.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    am_modulator_if.slave (en, phase_clr, ftw_load, car_ftw_in,
//          msg_ftw_in in; AM_mod, am_valid out)
module am_modulator
    import am_pkg::*;
#(
    parameter int unsigned  LUT_AW      = 10,
    parameter logic [31:0]  CAR_FTW_RST = CAR_FTW_DEFAULT,
    parameter logic [31:0]  MSG_FTW_RST = MSG_FTW_DEFAULT,
    parameter logic [7:0]   MOD_INDEX   = 8'd128
) (
    input  logic          clk,
    input  logic          rst_n,
    am_modulator_if.slave bus
);

    phase_t car_phase, msg_phase;
    phase_t car_ftw, msg_ftw;

    // Phase accumulators and tuning words. A load always lands, even
    // alongside phase_clr; the new word is used from the next increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_phase <= '0;
            msg_phase <= '0;
            car_ftw   <= CAR_FTW_RST;
            msg_ftw   <= MSG_FTW_RST;
        end else begin
            if (bus.phase_clr) begin
                car_phase <= '0;
                msg_phase <= '0;
            end else if (bus.en) begin
                car_phase <= car_phase + car_ftw;
                msg_phase <= msg_phase + msg_ftw;
            end
            if (bus.ftw_load) begin
                car_ftw <= bus.car_ftw_in;
                msg_ftw <= bus.msg_ftw_in;
            end
        end
    end

    // S1: ROM read of the current phases
    sample_t car_s1, msg_s1;
    logic    vld_s1;

    sine_rom #(.LUT_AW(LUT_AW)) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr_a (car_phase[PHASE_W-1 -: LUT_AW]),
        .addr_b (msg_phase[PHASE_W-1 -: LUT_AW]),
        .data_a (car_s1),
        .data_b (msg_s1)
    );

    // S2: envelope = 16384 + floor(msg*m_index / 512), always positive
    logic signed [ENV_W-1:0] msg_ext, mi_ext, msg_prod;
    sample_t                 env_next;

    always_comb begin
        msg_ext  = ENV_W'(msg_s1);
        mi_ext   = ENV_W'(MOD_INDEX);
        msg_prod = msg_ext * mi_ext;
        env_next = AM_W'(ENV_OFFSET) + AM_W'(msg_prod >>> ENV_SHIFT);
    end

    // S3: AM = floor(env*car / 32768); |AM| <= 32703 so no saturation
    logic signed [PROD_W-1:0] env_ext, car_ext, am_prod;
    sample_t                  am_next;
    sample_t                  env_s2, car_s2, am_q;
    logic                     vld_s2, vld_q;

    always_comb begin
        env_ext = PROD_W'(env_s2);
        car_ext = PROD_W'(car_s2);
        am_prod = env_ext * car_ext;
        am_next = AM_W'(am_prod >>> PROD_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_s1 <= 1'b0;
            env_s2 <= '0;
            car_s2 <= '0;
            vld_s2 <= 1'b0;
            am_q   <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_s1 <= bus.en;
            env_s2 <= env_next;
            car_s2 <= car_s1;
            vld_s2 <= vld_s1;
            am_q   <= am_next;
            vld_q  <= vld_s2;
        end
    end

    assign bus.AM_mod   = am_q;
    assign bus.am_valid = vld_q;

endmodule

// File: tb/tb_am_modulator.sv
// tb_am_modulator: three am_modulator instances (MOD_INDEX 0, 128, 255)
// driven by identical stimulus, checked against a sample-level model.
module tb_am_modulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      = 1'b1;
    logic        en         = 1'b0;
    logic        phase_clr  = 1'b0;
    logic        ftw_load   = 1'b0;
    logic [31:0] car_ftw_in = '0;
    logic [31:0] msg_ftw_in = '0;

    logic signed [15:0] obs_am [3];
    logic               obs_v  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        am_modulator_if bus ();
        assign bus.en         = en;
        assign bus.phase_clr  = phase_clr;
        assign bus.ftw_load   = ftw_load;
        assign bus.car_ftw_in = car_ftw_in;
        assign bus.msg_ftw_in = msg_ftw_in;
        assign obs_am[g]      = bus.AM_mod;
        assign obs_v[g]       = bus.am_valid;

        am_modulator #(
            .MOD_INDEX(g == 0 ? 8'd0 : (g == 1 ? 8'd128 : 8'd255))
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    typedef struct { int car; int msg; bit v; } samp_t;
    samp_t       pipe [$];
    bit [31:0]   m_car_ph, m_msg_ph, m_car_ftw, m_msg_ftw;
    int          exp_am [3];
    bit          exp_v;
    int          en_cnt;

    function automatic int mi_of(int d);
        return (d == 0) ? 0 : ((d == 1) ? 128 : 255);
    endfunction

    function automatic int sine_ref(bit [31:0] ph);
        real x;
        int  k;
        k = int'(ph[31:22]);
        x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * k / 1024.0);
        return (x >= 0.0) ? int'($floor(x + 0.5)) : -int'($floor(-x + 0.5));
    endfunction

    function automatic longint floor_div(longint a, longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int am_ref(int car, int msg, int mi);
        longint env;
        env = 16384 + floor_div(longint'(msg) * mi, 512);
        return int'(floor_div(env * car, 32768));
    endfunction

    task automatic model_reset();
        samp_t z;
        z.car = 0; z.msg = 0; z.v = 1'b0;
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
        m_car_ph  = '0;
        m_msg_ph  = '0;
        m_car_ftw = 32'h0400_0000;
        m_msg_ftw = 32'h0008_0000;
        for (int d = 0; d < 3; d++) exp_am[d] = 0;
        exp_v = 1'b0;
    endtask

    // One clock edge: sample the current phases, emit the sample taken
    // two edges earlier, then update phases and tuning words.
    task automatic model_step();
        samp_t s, o;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s.car = sine_ref(m_car_ph);
        s.msg = sine_ref(m_msg_ph);
        s.v   = en;
        if (en) en_cnt++;
        pipe.push_back(s);
        o = pipe.pop_front();
        for (int d = 0; d < 3; d++) exp_am[d] = am_ref(o.car, o.msg, mi_of(d));
        exp_v = o.v;
        if (phase_clr) begin
            m_car_ph = '0;
            m_msg_ph = '0;
        end else if (en) begin
            m_car_ph = m_car_ph + m_car_ftw;
            m_msg_ph = m_msg_ph + m_msg_ftw;
        end
        if (ftw_load) begin
            m_car_ftw = car_ftw_in;
            m_msg_ftw = msg_ftw_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        en = 1'b0; phase_clr = 1'b0; ftw_load = 1'b0;
        car_ftw_in = '0; msg_ftw_in = '0;
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_stream(logic [31:0] car, logic [31:0] msg);
        apply_reset();
        ftw_load = 1'b1; car_ftw_in = car; msg_ftw_in = msg;
        tick();
        ftw_load = 1'b0;
        en = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs_am[d] !== 16'sd0 || obs_v[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_async dut%0d: AM_mod=%0d am_valid=%b, required 0/0", d, obs_am[d], obs_v[d]);
            end
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (obs_am[d] !== 16'sd0 || obs_v[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_hold dut%0d cyc%0d: AM_mod=%0d am_valid=%b, required 0/0", d, c, obs_am[d], obs_v[d]);
                end
            end
        end
    endtask

    task automatic test_mod0();
        int seq [4] = '{0, 16383, 0, -16384};
        start_stream(32'h4000_0000, 32'h0);
        for (int n = 1; n <= 14; n++) begin
            tick();
            n_cmp++;
            if (n < 3) begin
                if (obs_v[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mod0_latency edge%0d: am_valid=%b, required 0", n, obs_v[0]);
                end
            end else if (obs_v[0] !== 1'b1 || obs_am[0] !== 16'(seq[(n-3)%4])) begin
                n_fail++;
                $display("FAIL mod0_seq edge%0d: AM_mod=%0d am_valid=%b, required %0d/1", n, obs_am[0], obs_v[0], seq[(n-3)%4]);
            end
        end
    endtask

    task automatic test_mod255();
        int seq [4] = '{0, 32702, 0, -64};
        start_stream(32'h4000_0000, 32'h4000_0000);
        for (int n = 1; n <= 14; n++) begin
            tick();
            if (n >= 3) begin
                n_cmp++;
                if (obs_v[2] !== 1'b1 || obs_am[2] !== 16'(seq[(n-3)%4])) begin
                    n_fail++;
                    $display("FAIL mod255_seq edge%0d: AM_mod=%0d am_valid=%b, required %0d/1", n, obs_am[2], obs_v[2], seq[(n-3)%4]);
                end
            end
        end
    endtask

    task automatic test_ftw_switch();
        start_stream(32'h4000_0000, 32'h0);
        tick();
        ftw_load = 1'b1; car_ftw_in = 32'h8000_0000; msg_ftw_in = 32'h0;
        tick();
        ftw_load = 1'b0;
        for (int n = 3; n <= 10; n++) begin
            int req;
            tick();
            req = (n == 4) ? 16383 : 0;
            n_cmp++;
            if (obs_v[0] !== 1'b1 || obs_am[0] !== 16'(req)) begin
                n_fail++;
                $display("FAIL ftw_switch edge%0d: AM_mod=%0d am_valid=%b, required %0d/1", n, obs_am[0], obs_v[0], req);
            end
        end
    endtask

    task automatic test_clr_load();
        int req [4] = '{16383, 0, 11585, 16383};
        start_stream(32'h4000_0000, 32'h0);
        repeat (5) tick();
        phase_clr = 1'b1; ftw_load = 1'b1;
        car_ftw_in = 32'h2000_0000; msg_ftw_in = 32'h0123_4567;
        tick();
        phase_clr = 1'b0; ftw_load = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (obs_v[0] !== 1'b1 || obs_am[0] !== 16'(req[i])) begin
                n_fail++;
                $display("FAIL clr_load clr+%0d: AM_mod=%0d am_valid=%b, required %0d/1", i + 2, obs_am[0], obs_v[0], req[i]);
            end
        end
    endtask

    task automatic test_random();
        int val_cnt;
        apply_reset();
        en_cnt  = 0;
        val_cnt = 0;
        for (int c = 0; c < 10003; c++) begin
            if (c < 10000) begin
                en         = 1'($urandom_range(0, 1));
                phase_clr  = ($urandom_range(0, 49) == 0);
                ftw_load   = ($urandom_range(0, 99) == 0);
                car_ftw_in = $urandom;
                msg_ftw_in = $urandom;
            end else begin
                en = 1'b0; phase_clr = 1'b0; ftw_load = 1'b0;
            end
            tick();
            if (obs_v[0] === 1'b1) val_cnt++;
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (obs_am[d] !== 16'(exp_am[d]) || obs_v[d] !== exp_v) begin
                    n_fail++;
                    $display("FAIL random_model dut%0d cyc%0d: AM_mod=%0d am_valid=%b, required %0d/%b", d, c, obs_am[d], obs_v[d], exp_am[d], exp_v);
                end
                n_cmp++;
                if (obs_am[d] > 16'sd32703 || obs_am[d] < -16'sd32703) begin
                    n_fail++;
                    $display("FAIL random_range dut%0d cyc%0d: AM_mod=%0d, required within +-32703", d, c, obs_am[d]);
                end
            end
        end
        n_cmp++;
        if (val_cnt != en_cnt) begin
            n_fail++;
            $display("FAIL valid_count: am_valid count=%0d, required en count=%0d", val_cnt, en_cnt);
        end

        // Asynchronous reset in the middle of a valid stream
        en = 1'b1;
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs_v[d] !== 1'b0 || obs_am[d] !== 16'sd0) begin
                n_fail++;
                $display("FAIL midrun_reset dut%0d: AM_mod=%0d am_valid=%b, required 0/0", d, obs_am[d], obs_v[d]);
            end
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (obs_am[d] !== 16'(exp_am[d]) || obs_v[d] !== exp_v) begin
                    n_fail++;
                    $display("FAIL post_reset dut%0d cyc%0d: AM_mod=%0d am_valid=%b, required %0d/%b", d, c, obs_am[d], obs_v[d], exp_am[d], exp_v);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        en_cnt = 0;
        test_reset();
        test_mod0();
        test_mod255();
        test_ftw_switch();
        test_clr_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
